// File: rtl/fp_float_to_int_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_float_to_int_conv_pkg
// Brief    : Shared widths, bias helpers and special-value classification
//            for the float-to-integer conversion path.
// Revision : 1.0 - initial release
// ============================================================================
package fp_float_to_int_conv_pkg;

  // Operand class produced by the exponent widening stage
  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_FINITE = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fpClass_t;

  // Width of the extended exponent (one bit wider than IEEE)
  function automatic int extExpW(input int expW);
    return expW + 1;
  endfunction

  // Bias of the extended exponent format: 2^expW - 1
  function automatic int extBias(input int expW);
    return (1 << expW) - 1;
  endfunction

  // Width of the significand shift amount
  function automatic int shamtW(input int intW, input int sigW);
    return $clog2(intW + sigW);
  endfunction

  function automatic logic isNaN(input logic expAllOnes, input logic sigNonZero);
    return expAllOnes & sigNonZero;
  endfunction

  function automatic logic isInf(input logic expAllOnes, input logic sigNonZero);
    return expAllOnes & ~sigNonZero;
  endfunction

  function automatic logic isZero(input logic expAllZero, input logic sigNonZero);
    return expAllZero & ~sigNonZero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_exp_widen.sv
`default_nettype none
// ============================================================================
// Module   : fp_exp_widen
// Brief    : Maps an IEEE exponent/significand pair to the extended-exponent
//            format (EXP_W+1 bits, bias 2^EXP_W-1). Subnormals are normalized
//            so that every finite nonzero operand carries an implicit one.
// Revision : 1.0 - initial release
// ============================================================================
module fp_exp_widen
  import fp_float_to_int_conv_pkg::*;
#(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8
) (
  input  logic [EXP_W-1:0] i_exp,
  input  logic [SIG_W-1:0] i_sig,
  output logic [EXP_W:0]   o_extExp,
  output logic [SIG_W-1:0] o_sig,
  output fpClass_t         o_cls
);

  localparam int c_LZW = $clog2(SIG_W + 1);

  // Offset between IEEE bias and extended bias
  localparam logic [EXP_W:0] c_REBIAS = (EXP_W + 1)'(2 ** (EXP_W - 1));

  logic             w_expMax;
  logic             w_expZero;
  logic             w_sigNz;
  logic [c_LZW-1:0] w_lz;

  // Raw field classification
  always_comb begin
    w_expMax  = &i_exp;
    w_expZero = ~|i_exp;
    w_sigNz   = |i_sig;
  end

  // Leading-zero count of the significand (highest set bit wins)
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < SIG_W; i++) begin
      if (i_sig[i]) w_lz = c_LZW'(SIG_W - 1 - i);
    end
  end

  // Re-bias normals, normalize subnormals, pin specials to the extremes
  always_comb begin
    o_extExp = {1'b0, i_exp} + c_REBIAS;
    o_sig    = i_sig;
    o_cls    = CLS_FINITE;
    if (isNaN(w_expMax, w_sigNz)) begin
      o_extExp = '1;
      o_cls    = CLS_NAN;
    end else if (isInf(w_expMax, w_sigNz)) begin
      o_extExp = '1;
      o_cls    = CLS_INF;
    end else if (isZero(w_expZero, w_sigNz)) begin
      o_extExp = '0;
      o_cls    = CLS_ZERO;
    end else if (w_expZero) begin
      // Leading one moves to the implicit position and is dropped
      o_extExp = c_REBIAS - (EXP_W + 1)'(w_lz);
      o_sig    = i_sig << (w_lz + c_LZW'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_float_to_int_conv.sv
`default_nettype none
// ============================================================================
// Module   : fp_float_to_int_conv
// Brief    : IEEE float to signed/unsigned integer conversion with
//            round-toward-zero and saturation (RISC-V FCVT semantics).
//            One cycle of latency, one operation per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fp_float_to_int_conv
  import fp_float_to_int_conv_pkg::*;
#(
  parameter int INT_W = 64,
  parameter int SIG_W = 23,
  parameter int EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [EXP_W+SIG_W:0]   a_i,
  input  logic                   to_signed,
  input  logic                   half_width,
  output logic                   out_valid,
  output logic [INT_W-1:0]       z_o
);

  localparam int c_EXTW = extExpW(EXP_W);
  localparam int c_SHW  = shamtW(INT_W, SIG_W);
  localparam logic signed [c_EXTW:0] c_BIAS = (c_EXTW + 1)'(extBias(EXP_W));

  logic                     w_sign;
  logic [c_EXTW-1:0]        w_extExp;
  logic [SIG_W-1:0]         w_sig;
  fpClass_t                 w_cls;
  logic signed [c_EXTW:0]   w_unbExp;
  logic signed [c_EXTW:0]   w_nm1;
  logic                     w_fracOnly;
  logic                     w_over;
  logic                     w_atTop;
  logic [c_SHW-1:0]         w_eU;
  logic [INT_W-1:0]         w_mant;
  logic [INT_W-1:0]         w_mag;
  logic [INT_W-1:0]         w_maxPos;
  logic [INT_W-1:0]         w_minNeg;
  logic [INT_W-1:0]         w_raw;
  logic [INT_W-1:0]         w_result;
  logic [INT_W-1:0]         r_z;
  logic                     r_valid;

  assign w_sign = a_i[EXP_W+SIG_W];

  fp_exp_widen #(
    .SIG_W (SIG_W),
    .EXP_W (EXP_W)
  ) u_widen (
    .i_exp    (a_i[EXP_W+SIG_W-1:SIG_W]),
    .i_sig    (a_i[SIG_W-1:0]),
    .o_extExp (w_extExp),
    .o_sig    (w_sig),
    .o_cls    (w_cls)
  );

  // Unbiased exponent and range checks against the target width N
  always_comb begin
    w_unbExp   = $signed({1'b0, w_extExp}) - c_BIAS;
    w_nm1      = half_width ? (c_EXTW + 1)'(31) : (c_EXTW + 1)'(INT_W - 1);
    w_fracOnly = w_unbExp[c_EXTW];
    w_over     = w_unbExp > w_nm1;
    w_atTop    = w_unbExp == w_nm1;
    w_eU       = w_unbExp[c_SHW-1:0];
  end

  // Truncated magnitude: align the integer part of 1.sig to bit 0
  always_comb begin
    w_mant = INT_W'({1'b1, w_sig});
    if (w_eU >= c_SHW'(SIG_W)) w_mag = w_mant << (w_eU - c_SHW'(SIG_W));
    else                       w_mag = w_mant >> (c_SHW'(SIG_W) - w_eU);
  end

  // Saturation limits; half-width values are sign-extended from bit 31 later
  always_comb begin
    w_maxPos = '1;
    if (to_signed) w_maxPos = half_width ? INT_W'(32'h7FFF_FFFF) : {1'b0, {(INT_W-1){1'b1}}};
    w_minNeg = half_width ? INT_W'(32'h8000_0000) : {1'b1, {(INT_W-1){1'b0}}};
  end

  // Select the converted value or the saturated replacement.
  // A negative value at e = N-1 always lands on -2^(N-1): either it is exact
  // or it overflows and saturates to the same pattern.
  always_comb begin
    w_raw = '0;
    if (w_cls == CLS_NAN) begin
      w_raw = w_maxPos;
    end else if (w_cls == CLS_INF) begin
      if (!w_sign)        w_raw = w_maxPos;
      else if (to_signed) w_raw = w_minNeg;
    end else if (w_fracOnly) begin
      w_raw = '0;
    end else if (!w_sign) begin
      w_raw = (w_over || (to_signed && w_atTop)) ? w_maxPos : w_mag;
    end else if (to_signed) begin
      w_raw = (w_over || w_atTop) ? w_minNeg : -w_mag;
    end
  end

  generate
    if (INT_W > 32) begin : g_wide
      // 32-bit results are sign-extended from bit 31 in both modes
      always_comb begin
        w_result = half_width ? {{(INT_W-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
      end
    end else begin : g_narrow
      always_comb begin
        w_result = w_raw;
      end
    end
  endgenerate

  // Output register; holds its value while no operation is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_z     <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_z <= w_result;
    end
  end

  assign out_valid = r_valid;
  assign z_o       = r_z;

endmodule
`default_nettype wire

// File: tb/tb_fp_float_to_int_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_float_to_int_conv
// Brief    : Directed self-checking bench for fp_float_to_int_conv (FP32,
//            64-bit integer result).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_float_to_int_conv;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] a_i;
  logic        to_signed;
  logic        half_width;
  logic        out_valid;
  logic [63:0] z_o;

  int nChecks;
  int nPass;

  fp_float_to_int_conv #(
    .INT_W (64),
    .SIG_W (23),
    .EXP_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .a_i        (a_i),
    .to_signed  (to_signed),
    .half_width (half_width),
    .out_valid  (out_valid),
    .z_o        (z_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Issue one operation; returns #1 after the edge that registers it
  task automatic doOp(input logic [31:0] a, input logic s, input logic h);
    @(posedge clk); #1;
    a_i = a; to_signed = s; half_width = h; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; a_i = 32'h3F80_0000; to_signed = 1'b1; half_width = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    nChecks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: out_valid=%b required 0", out_valid);
    else nPass++;
    nChecks++;
    if (z_o !== 64'h0) $display("FAIL reset_z: z_o=%h required 0", z_o);
    else nPass++;
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_rtz();
    logic [31:0] av [0:3];
    logic        sv [0:3];
    logic        hv [0:3];
    logic [63:0] ev [0:3];
    av = '{32'h3FC0_0000, 32'hC030_0000, 32'h3F80_0000, 32'h42C8_0000};
    sv = '{1'b1, 1'b1, 1'b0, 1'b0};
    hv = '{1'b0, 1'b0, 1'b0, 1'b1};
    ev = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h64};
    for (int k = 0; k < 4; k++) begin
      doOp(av[k], sv[k], hv[k]);
      nChecks++;
      if (z_o !== ev[k] || out_valid !== 1'b1)
        $display("FAIL rtz[%0d] a=%h: z_o=%h out_valid=%b required z_o=%h out_valid=1",
                 k, av[k], z_o, out_valid, ev[k]);
      else nPass++;
    end
  endtask

  task automatic test_boundary();
    logic [31:0] av [0:6];
    logic        sv [0:6];
    logic        hv [0:6];
    logic [63:0] ev [0:6];
    av = '{32'h5F00_0000, 32'hDF00_0000, 32'h5F00_0000, 32'h4F00_0000,
           32'h4F00_0000, 32'hCF00_0000, 32'h5F80_0000};
    sv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    hv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ev = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
           64'hFFFF_FFFF_FFFF_FFFF};
    for (int k = 0; k < 7; k++) begin
      doOp(av[k], sv[k], hv[k]);
      nChecks++;
      if (z_o !== ev[k])
        $display("FAIL boundary[%0d] a=%h s=%b h=%b: z_o=%h required %h",
                 k, av[k], sv[k], hv[k], z_o, ev[k]);
      else nPass++;
    end
  endtask

  task automatic test_specials();
    logic [31:0] av [0:4];
    logic        sv [0:4];
    logic        hv [0:4];
    logic [63:0] ev [0:4];
    av = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'hFF80_0000, 32'h7F80_0000};
    sv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    hv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ev = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'h0, 64'h0000_0000_7FFF_FFFF};
    for (int k = 0; k < 5; k++) begin
      doOp(av[k], sv[k], hv[k]);
      nChecks++;
      if (z_o !== ev[k])
        $display("FAIL special[%0d] a=%h s=%b h=%b: z_o=%h required %h",
                 k, av[k], sv[k], hv[k], z_o, ev[k]);
      else nPass++;
    end
  endtask

  task automatic test_small();
    logic [31:0] av [0:5];
    logic        sv [0:5];
    av = '{32'hBF00_0000, 32'hC000_0000, 32'h0000_0001, 32'h8000_0000,
           32'hBF00_0000, 32'h8040_0000};
    sv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      // Preload a nonzero result so a stale register cannot pass
      doOp(32'h42C8_0000, 1'b1, 1'b0);
      doOp(av[k], sv[k], 1'b0);
      nChecks++;
      if (z_o !== 64'h0)
        $display("FAIL small[%0d] a=%h s=%b: z_o=%h required 0", k, av[k], sv[k], z_o);
      else nPass++;
    end
  endtask

  task automatic test_hold();
    doOp(32'h42C8_0000, 1'b1, 1'b0);
    nChecks++;
    if (z_o !== 64'd100) $display("FAIL hold_load: z_o=%h required %h", z_o, 64'd100);
    else nPass++;
    a_i = 32'h3F80_0000;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      nChecks++;
      if (z_o !== 64'd100 || out_valid !== 1'b0)
        $display("FAIL hold[%0d]: z_o=%h out_valid=%b required z_o=%h out_valid=0",
                 k, z_o, out_valid, 64'd100);
      else nPass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [0:3];
    logic [63:0] ev [0:3];
    av = '{32'h3F80_0000, 32'h42C8_0000, 32'hBF80_0000, 32'h4070_0000};
    ev = '{64'h1, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        nChecks++;
        if (z_o !== ev[k-1] || out_valid !== 1'b1)
          $display("FAIL b2b[%0d]: z_o=%h out_valid=%b required z_o=%h out_valid=1",
                   k - 1, z_o, out_valid, ev[k-1]);
        else nPass++;
      end
      if (k < 4) begin
        a_i = av[k]; to_signed = 1'b1; half_width = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    a_i = 32'h4040_0000; to_signed = 1'b1; half_width = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if (z_o !== 64'h3 || out_valid !== 1'b1)
      $display("FAIL mid_first: z_o=%h out_valid=%b required z_o=3 out_valid=1", z_o, out_valid);
    else nPass++;
    a_i = 32'h42C8_0000; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    nChecks++;
    if (z_o !== 64'h0 || out_valid !== 1'b0)
      $display("FAIL mid_reset: z_o=%h out_valid=%b required z_o=0 out_valid=0", z_o, out_valid);
    else nPass++;
    @(posedge clk); #1;
    nChecks++;
    if (z_o !== 64'h0 || out_valid !== 1'b0)
      $display("FAIL mid_dropped: z_o=%h out_valid=%b required z_o=0 out_valid=0", z_o, out_valid);
    else nPass++;
  endtask

  initial begin
    nChecks = 0; nPass = 0;
    reset = 1'b0; in_valid = 1'b0; a_i = '0; to_signed = 1'b0; half_width = 1'b0;
    test_reset();
    test_rtz();
    test_boundary();
    test_specials();
    test_small();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
